// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/decode/execute sequencer for a LEGv8-style core.
// It drives the program counter's select (PS) and branch operand, and issues one
// PC update per retired instruction.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   imem_ready, instr   instruction-memory handshake and fetched word
//   zero, flags         ALU zero flag and {N,Z,C,V}, sampled in EXEC
//   dmem_ready          data access complete
//   imem_req, ir_load   fetch request and IR load strobe (ir_load = FETCH & imem_ready)
//   ir                  latched instruction
//   PS                  00 hold, 01 PC+4, 10 PC<=in, 11 PC+4+in*4
//   branch_offset       imm - 1 in words, so that PC+4+in*4 lands on PC+imm*4
//   pc_in_sel, br_reg   BR register select and source register ir[9:5]
//   mem_req, mem_write  data memory request; write asserted for STUR
//   instr_count         retired-instruction counter
//   halted, fault       sticky terminal states
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ready (bounded by TIMEOUT)
// DECODE | detect HLT
// EXEC   | classify instruction, resolve branch condition
// MEM    | wait for dmem_ready on LDUR/STUR (bounded by TIMEOUT)
// UPDATE | one-cycle PC update pulse, count retired instruction
// HALT   | stopped by HLT until reset
// FAULT  | memory timeout, stopped until reset
module pc_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic [3:0]  flags,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic [31:0] ir,
  output logic [1:0]  PS,
  output logic [63:0] branch_offset,
  output logic        pc_in_sel,
  output logic [4:0]  br_reg,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic        fault
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [31:0] HLT_WORD = 32'hD440_0000;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [WW-1:0] wcnt;
  logic          taken;

  logic op_b, op_cbz, op_cbnz, op_bcond, op_br, op_ldur, op_stur;

  assign op_b     = (ir[31:26] == 6'b000101) || (ir[31:26] == 6'b100101);
  assign op_cbz   = (ir[31:24] == 8'hB4);
  assign op_cbnz  = (ir[31:24] == 8'hB5);
  assign op_bcond = (ir[31:24] == 8'h54);
  assign op_br    = (ir[31:21] == 11'b11010110000);
  assign op_ldur  = (ir[31:21] == 11'b11111000010);
  assign op_stur  = (ir[31:21] == 11'b11111000000);

  // flags = {N,Z,C,V}
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_true = z;
      4'h1:    cond_true = ~z;
      4'h2:    cond_true = cy;
      4'h3:    cond_true = ~cy;
      4'h4:    cond_true = n;
      4'h5:    cond_true = ~n;
      4'h6:    cond_true = v;
      4'h7:    cond_true = ~v;
      4'h8:    cond_true = cy & ~z;
      4'h9:    cond_true = ~(cy & ~z);
      4'hA:    cond_true = (n == v);
      4'hB:    cond_true = (n != v);
      4'hC:    cond_true = ~z & (n == v);
      4'hD:    cond_true = ~(~z & (n == v));
      default: cond_true = 1'b1;
    endcase
  endfunction

  // Offset is a pure function of the latched IR, so it is stable for the whole
  // EXEC..UPDATE window without a separate register.
  always_comb begin
    branch_offset = 64'd0;
    if (op_b)
      branch_offset = {{38{ir[25]}}, ir[25:0]} - 64'd1;
    else if (op_cbz || op_cbnz || op_bcond)
      branch_offset = {{45{ir[23]}}, ir[23:5]} - 64'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      ir          <= 32'd0;
      wcnt        <= '0;
      instr_count <= 32'd0;
      taken       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir    <= instr;
            state <= S_DECODE;
          end else if (wcnt == WLAST) begin
            state <= S_FAULT;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_DECODE: state <= (ir == HLT_WORD) ? S_HALT : S_EXEC;
        S_EXEC: begin
          taken <= op_b | (op_cbz & zero) | (op_cbnz & ~zero) |
                   (op_bcond & cond_true(ir[3:0], flags));
          if (op_ldur || op_stur) begin
            wcnt  <= '0;
            state <= S_MEM;
          end else begin
            state <= S_UPDATE;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state <= S_UPDATE;
          end else if (wcnt == WLAST) begin
            state <= S_FAULT;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_UPDATE: begin
          instr_count <= instr_count + 32'd1;
          wcnt        <= '0;
          state       <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  always_comb begin
    PS = 2'b00;
    if (state == S_UPDATE) begin
      if (taken)      PS = 2'b11;
      else if (op_br) PS = 2'b10;
      else            PS = 2'b01;
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign ir_load   = (state == S_FETCH) && imem_ready;
  assign mem_req   = (state == S_MEM);
  assign mem_write = (state == S_MEM) && op_stur;
  assign pc_in_sel = op_br && ((state == S_EXEC) || (state == S_UPDATE));
  assign br_reg    = ir[9:5];
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_load, pc_in_sel, mem_req, mem_write, halted, fault;
  logic [31:0] ir, instr_count;
  logic [1:0]  PS;
  logic [63:0] branch_offset;
  logic [4:0]  br_reg;

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;

  pc_sequencer #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .imem_ready(imem_ready), .instr(instr),
    .zero(zero), .flags(flags), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_load(ir_load), .ir(ir), .PS(PS), .branch_offset(branch_offset),
    .pc_in_sel(pc_in_sel), .br_reg(br_reg), .mem_req(mem_req),
    .mem_write(mem_write), .instr_count(instr_count), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic longint sext(input longint raw, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (raw >= half) ? raw - (half * 2) : raw;
  endfunction

  // Runs one instruction from the FETCH period; called at #1 after a posedge.
  task automatic run_instr(input logic [31:0] w, input logic z, input logic [3:0] f,
                           input int iw, input int dw);
    bit is_b, is_cb, is_bc, is_br, is_ld, is_st, is_mem, tk, has_off;
    longint off;
    logic [1:0] eps;
    int pulse;
    is_b  = (w[31:26] == 6'b000101) || (w[31:26] == 6'b100101);
    is_cb = (w[31:25] == 7'b1011010);
    is_bc = (w[31:24] == 8'h54);
    is_br = (w[31:21] == 11'b11010110000);
    is_ld = (w[31:21] == 11'b11111000010);
    is_st = (w[31:21] == 11'b11111000000);
    is_mem = is_ld || is_st;
    tk = is_b || (is_cb && (w[24] ? !z : z)) || (is_bc && cond_holds(w[3:0], f));
    has_off = is_b || is_cb || is_bc;
    off = is_b ? sext(longint'(w[25:0]), 26) - 1 : sext(longint'(w[23:5]), 19) - 1;
    pulse = iw + 4 + (is_mem ? dw + 1 : 0);
    for (int k = 1; k <= pulse; k++) begin
      instr = w; zero = z; flags = f;
      imem_ready = (k == iw + 1);
      dmem_ready = is_mem && (k == iw + 4 + dw);
      @(negedge clock);
      if (k == 1) chk("instr_count", instr_count, exp_count);
      chk("imem_req", imem_req, k <= iw + 1);
      chk("ir_load", ir_load, k == iw + 1);
      chk("mem_req", mem_req, is_mem && k >= iw + 4 && k <= iw + 4 + dw);
      chk("mem_write", mem_write, is_st && k >= iw + 4 && k <= iw + 4 + dw);
      eps = (k != pulse) ? 2'b00 : tk ? 2'b11 : is_br ? 2'b10 : 2'b01;
      chk("PS", PS, eps);
      if (k == pulse) begin
        chk("pc_in_sel", pc_in_sel, is_br);
        if (has_off) chk("branch_offset", branch_offset, off);
        if (is_br) chk("br_reg", br_reg, w[9:5]);
      end
      @(posedge clock); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_count++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 8))
      0: return {11'b10001011000, r[20:0]};
      1: return {6'b000101, r[25:0]};
      2: return {6'b100101, r[25:0]};
      3: return {8'hB4, r[23:0]};
      4: return {8'hB5, r[23:0]};
      5: return {8'h54, r[23:0]};
      6: return {11'b11010110000, 5'b11111, 6'b0, r[4:0], 5'b0};
      7: return {11'b11111000010, r[20:0]};
      default: return {11'b11111000000, r[20:0]};
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_count = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_imem_req", imem_req, 1'b1);
    chk("rst_PS", PS, 2'b00);
    chk("rst_ir", ir, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_misc", {mem_req, mem_write, halted, fault, pc_in_sel, branch_offset}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_instr(32'h8B02_0020, 1'b0, 4'h0, 0, 0);
    run_instr({6'b000101, 26'd3}, 1'b0, 4'h0, 0, 0);
    run_instr({6'b000101, 26'h3FF_FFFF}, 1'b0, 4'h0, 1, 0);
    run_instr({8'hB4, 19'd10, 5'd1}, 1'b1, 4'h0, 0, 0);
    run_instr({8'hB4, 19'd10, 5'd1}, 1'b0, 4'h0, 0, 0);
    run_instr({8'h54, 19'h7FFF0, 1'b0, 4'hC}, 1'b0, 4'b1001, 0, 0);
    run_instr({8'h54, 19'h7FFF0, 1'b0, 4'hC}, 1'b0, 4'b1101, 0, 0);
    run_instr({11'b11010110000, 5'b11111, 6'b0, 5'd5, 5'd0}, 1'b0, 4'h0, 0, 0);
    run_instr({11'b11111000000, 21'h1234}, 1'b0, 4'h0, 0, 2);

    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), 1'($urandom), 4'($urandom), $urandom_range(0, 5),
                $urandom_range(0, 5));

    // HLT: stays halted with no requests and no PC update
    instr = 32'hD440_0000; imem_ready = 1'b1;
    @(negedge clock);
    chk("hlt_count", instr_count, exp_count);
    @(posedge clock); #1; imem_ready = 1'b0;
    @(posedge clock); #1;
    for (int k = 0; k < 6; k++) begin
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      @(negedge clock);
      chk("halted", halted, 1'b1);
      chk("hlt_PS", PS, 2'b00);
      chk("hlt_req", {imem_req, mem_req, fault}, 3'b000);
      @(posedge clock); #1;
    end
    do_reset();

    // reset asserted in the middle of a MEM wait
    run_instr(32'h8B02_0020, 1'b0, 4'h0, 0, 0);
    instr = {11'b11111000010, 21'h55}; imem_ready = 1'b1;
    @(posedge clock); #1; imem_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("mid_mem_req", mem_req, 1'b1);
    chk("mid_count", instr_count, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstmem_state", {imem_req, mem_req, PS}, 4'b1000);
    chk("rstmem_count", instr_count, 32'd0);
    exp_count = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    run_instr(32'h8B02_0020, 1'b0, 4'h0, 0, 0);
    @(negedge clock);
    chk("post_count", instr_count, 32'd1);
    @(posedge clock); #1;

    // fetch timeout
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      imem_ready = 1'b0;
      @(negedge clock);
      chk("to_wait", {fault, imem_req}, 2'b01);
      @(posedge clock); #1;
    end
    for (int k = 0; k < 8; k++) begin
      imem_ready = 1'b1; dmem_ready = 1'($urandom);
      @(negedge clock);
      chk("fault", fault, 1'b1);
      chk("fault_PS", PS, 2'b00);
      chk("fault_req", {imem_req, ir_load, mem_req, halted}, 4'b0000);
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
